// File: rtl/ace_pkg.sv
// Shared ACE snoop definitions: ACSNOOP codes, CRRESP layout,
// responder FSM states and the snoop response/update decision.
package ace_pkg;

    localparam logic [3:0] AC_READ_ONCE     = 4'b0000;
    localparam logic [3:0] AC_READ_SHARED   = 4'b0001;
    localparam logic [3:0] AC_READ_CLEAN    = 4'b0010;
    localparam logic [3:0] AC_READ_NSD      = 4'b0011;
    localparam logic [3:0] AC_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] AC_CLEAN_SHARED  = 4'b1000;
    localparam logic [3:0] AC_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] AC_MAKE_INVALID  = 4'b1101;

    localparam int CR_DT_BIT  = 0;
    localparam int CR_ERR_BIT = 1;
    localparam int CR_PD_BIT  = 2;
    localparam int CR_IS_BIT  = 3;
    localparam int CR_WU_BIT  = 4;

    // Field order matches CRRESP bit positions, MSB first.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_xfer;
    } crresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_RESP,
        ST_DATA
    } snoop_state_e;

    typedef struct packed {
        crresp_t resp;
        logic    upd;
        logic    inv;
        logic    clean;
    } snoop_dec_t;

    // Response and cache-state update for one snoop given the line state.
    // Unsupported codes report Error and ignore the lookup result.
    function automatic snoop_dec_t snoop_decide(
        input logic [3:0] snoop,
        input logic       hit,
        input logic       dirty,
        input logic       uniq
    );
        snoop_dec_t d;
        d = '0;
        unique case (snoop)
            AC_READ_ONCE: begin
                if (hit) begin
                    d.resp.data_xfer  = 1'b1;
                    d.resp.is_shared  = 1'b1;
                    d.resp.was_unique = uniq;
                end
            end
            AC_READ_SHARED, AC_READ_CLEAN, AC_READ_NSD: begin
                if (hit) begin
                    d.resp.data_xfer  = 1'b1;
                    d.resp.is_shared  = 1'b1;
                    d.resp.pass_dirty = dirty;
                    d.resp.was_unique = uniq;
                    d.upd             = 1'b1;
                    d.clean           = 1'b1;
                end
            end
            AC_READ_UNIQUE: begin
                if (hit) begin
                    d.resp.data_xfer  = 1'b1;
                    d.resp.pass_dirty = dirty;
                    d.resp.was_unique = uniq;
                    d.upd             = 1'b1;
                    d.inv             = 1'b1;
                end
            end
            AC_CLEAN_SHARED: begin
                if (hit) begin
                    d.resp.data_xfer  = dirty;
                    d.resp.is_shared  = 1'b1;
                    d.resp.pass_dirty = dirty;
                    d.resp.was_unique = uniq;
                    d.upd             = 1'b1;
                    d.clean           = 1'b1;
                end
            end
            AC_CLEAN_INVALID: begin
                if (hit) begin
                    d.resp.data_xfer  = dirty;
                    d.resp.pass_dirty = dirty;
                    d.resp.was_unique = uniq;
                    d.upd             = 1'b1;
                    d.inv             = 1'b1;
                end
            end
            AC_MAKE_INVALID: begin
                if (hit) begin
                    d.resp.was_unique = uniq;
                    d.upd             = 1'b1;
                    d.inv             = 1'b1;
                end
            end
            default: begin
                d.resp.error = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ace_cd_serializer.sv
// Holds one cache line and streams it out beat by beat with valid/last.
// Ports: load_i/line_i capture a line, start_i raises valid at beat 0,
// valid_o/ready_i/data_o/last_o form the outgoing beat handshake.
module ace_cd_serializer #(
    parameter int DataWidth = 64,
    parameter int CdBeats   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         load_i,
    input  logic [DataWidth*CdBeats-1:0] line_i,
    input  logic                         start_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         last_o
);

    localparam int CntW = (CdBeats > 1) ? $clog2(CdBeats) : 1;

    logic [DataWidth*CdBeats-1:0] line_q;
    logic [CntW-1:0]              cnt_q;
    logic                         valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_i) begin
                line_q <= line_i;
            end
            if (start_i) begin
                valid_q <= 1'b1;
                cnt_q   <= '0;
            end else if (valid_q && ready_i) begin
                if (last_o) begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = line_q[int'(cnt_q)*DataWidth +: DataWidth];
    assign last_o  = (cnt_q == CntW'(CdBeats - 1));

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC request -> cache lookup -> CR response
// -> optional CD line, with a clean/invalidate update pulse to the cache.
module ace_snoop_responder
    import ace_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int CdBeats   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ac_valid_i,
    output logic                         ac_ready_o,
    input  logic [AddrWidth-1:0]         ac_addr_i,
    input  logic [3:0]                   ac_snoop_i,
    input  logic [2:0]                   ac_prot_i,
    output logic                         cr_valid_o,
    input  logic                         cr_ready_i,
    output logic [4:0]                   cr_resp_o,
    output logic                         cd_valid_o,
    input  logic                         cd_ready_i,
    output logic [DataWidth-1:0]         cd_data_o,
    output logic                         cd_last_o,
    output logic                         lookup_req_o,
    input  logic                         lookup_gnt_i,
    output logic [AddrWidth-1:0]         lookup_addr_o,
    input  logic                         lookup_valid_i,
    input  logic                         lookup_hit_i,
    input  logic                         lookup_dirty_i,
    input  logic                         lookup_unique_i,
    input  logic [DataWidth*CdBeats-1:0] lookup_data_i,
    output logic                         upd_valid_o,
    output logic [AddrWidth-1:0]         upd_addr_o,
    output logic                         upd_invalidate_o,
    output logic                         upd_clean_o
);

    localparam int LineBytes = DataWidth / 8 * CdBeats;
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(LineBytes - 1);

    snoop_state_e         state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic                 lookup_req_q;
    logic                 cr_valid_q;
    crresp_t              cr_resp_q;

    snoop_dec_t dec;
    logic       accept;
    logic       cr_hs;
    logic       cd_done;
    logic       unused_prot;

    assign unused_prot = ^ac_prot_i;

    assign dec = snoop_decide(snoop_q, lookup_hit_i,
                              lookup_dirty_i, lookup_unique_i);

    // A result in the grant cycle counts as if it arrived in WAIT.
    assign accept = lookup_valid_i &&
                    ((state_q == ST_WAIT) ||
                     (state_q == ST_LOOKUP && lookup_gnt_i));

    assign cr_hs   = cr_valid_q && cr_ready_i;
    assign cd_done = cd_valid_o && cd_ready_i && cd_last_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            snoop_q      <= '0;
            lookup_req_q <= 1'b0;
            cr_valid_q   <= 1'b0;
            cr_resp_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ac_valid_i) begin
                        addr_q       <= ac_addr_i & LineMask;
                        snoop_q      <= ac_snoop_i;
                        lookup_req_q <= 1'b1;
                        state_q      <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_gnt_i) begin
                        lookup_req_q <= 1'b0;
                        if (accept) begin
                            cr_valid_q <= 1'b1;
                            cr_resp_q  <= dec.resp;
                            state_q    <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        cr_valid_q <= 1'b1;
                        cr_resp_q  <= dec.resp;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cr_hs) begin
                        cr_valid_q <= 1'b0;
                        state_q    <= cr_resp_q.data_xfer ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cd_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    ace_cd_serializer #(
        .DataWidth (DataWidth),
        .CdBeats   (CdBeats)
    ) u_cd (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (accept),
        .line_i  (lookup_data_i),
        .start_i (cr_hs && cr_resp_q.data_xfer),
        .valid_o (cd_valid_o),
        .ready_i (cd_ready_i),
        .data_o  (cd_data_o),
        .last_o  (cd_last_o)
    );

    assign ac_ready_o    = (state_q == ST_IDLE);
    assign lookup_req_o  = lookup_req_q;
    assign lookup_addr_o = addr_q;
    assign cr_valid_o    = cr_valid_q;
    assign cr_resp_o     = cr_resp_q;

    // The cache takes the update in the same cycle the result arrives.
    assign upd_valid_o      = accept && dec.upd;
    assign upd_addr_o       = addr_q;
    assign upd_invalidate_o = accept && dec.inv;
    assign upd_clean_o      = accept && dec.clean;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: directed plan cases plus
// randomized snoops checked against a rule-level response model.
module tb_ace_snoop_responder;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          ac_valid_i;
    logic          ac_ready_o;
    logic [AW-1:0] ac_addr_i;
    logic [3:0]    ac_snoop_i;
    logic [2:0]    ac_prot_i;
    logic          cr_valid_o;
    logic          cr_ready_i;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o;
    logic          cd_ready_i;
    logic [DW-1:0] cd_data_o;
    logic          cd_last_o;
    logic          lookup_req_o;
    logic          lookup_gnt_i;
    logic [AW-1:0] lookup_addr_o;
    logic          lookup_valid_i;
    logic          lookup_hit_i;
    logic          lookup_dirty_i;
    logic          lookup_unique_i;
    logic [DW*NB-1:0] lookup_data_i;
    logic          upd_valid_o;
    logic [AW-1:0] upd_addr_o;
    logic          upd_invalidate_o;
    logic          upd_clean_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ace_snoop_responder #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .CdBeats   (NB)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .ac_valid_i       (ac_valid_i),
        .ac_ready_o       (ac_ready_o),
        .ac_addr_i        (ac_addr_i),
        .ac_snoop_i       (ac_snoop_i),
        .ac_prot_i        (ac_prot_i),
        .cr_valid_o       (cr_valid_o),
        .cr_ready_i       (cr_ready_i),
        .cr_resp_o        (cr_resp_o),
        .cd_valid_o       (cd_valid_o),
        .cd_ready_i       (cd_ready_i),
        .cd_data_o        (cd_data_o),
        .cd_last_o        (cd_last_o),
        .lookup_req_o     (lookup_req_o),
        .lookup_gnt_i     (lookup_gnt_i),
        .lookup_addr_o    (lookup_addr_o),
        .lookup_valid_i   (lookup_valid_i),
        .lookup_hit_i     (lookup_hit_i),
        .lookup_dirty_i   (lookup_dirty_i),
        .lookup_unique_i  (lookup_unique_i),
        .lookup_data_i    (lookup_data_i),
        .upd_valid_o      (upd_valid_o),
        .upd_addr_o       (upd_addr_o),
        .upd_invalidate_o (upd_invalidate_o),
        .upd_clean_o      (upd_clean_o)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {upd, inv, clean, WU, IS, PD, Err, DT} from the snoop rules.
    function automatic logic [7:0] model(input logic [3:0] c,
                                         input logic hit, input logic dirty,
                                         input logic uniq);
        logic sup, reads, cleans, dt, is, pd, inv, cl;
        sup = c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
        if (!sup) return 8'b000_00010;
        if (!hit) return 8'h00;
        reads  = c inside {[4'd0:4'd3], 4'd7};
        cleans = c inside {4'd8, 4'd9};
        dt  = reads | (cleans & dirty);
        is  = c inside {[4'd0:4'd3], 4'd8};
        pd  = dirty && c != 4'd0 && c != 4'd13;
        inv = c inside {4'd7, 4'd9, 4'd13};
        cl  = c inside {[4'd1:4'd3], 4'd8};
        return {inv | cl, inv, cl, uniq, is, pd, 1'b0, dt};
    endfunction

    task automatic give_result(input logic hit, input logic dirty,
                               input logic uniq, input logic [DW*NB-1:0] line,
                               input logic [7:0] m, input logic [AW-1:0] aa);
        lookup_valid_i  = 1'b1;
        lookup_hit_i    = hit;
        lookup_dirty_i  = dirty;
        lookup_unique_i = uniq;
        lookup_data_i   = line;
        #1;
        check("upd_valid", upd_valid_o, m[7]);
        if (m[7]) begin
            check("upd_invalidate", upd_invalidate_o, m[6]);
            check("upd_clean", upd_clean_o, m[5]);
            check("upd_addr", upd_addr_o, aa);
        end
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_snoop(input logic [3:0] c, input logic [AW-1:0] a,
                             input logic hit, input logic dirty,
                             input logic uniq, input logic [DW*NB-1:0] line,
                             input int gnt_dly, input bit same,
                             input int wait_dly, input int stall_max,
                             input int abort_beat);
        logic [7:0]    m;
        logic [4:0]    er;
        logic [AW-1:0] aa;
        int            n;
        m  = model(c, hit, dirty, uniq);
        er = m[4:0];
        aa = a & ~64'h1f;

        check("ac_ready_idle", ac_ready_o, 1'b1);
        ac_valid_i = 1'b1;
        ac_addr_i  = a;
        ac_snoop_i = c;
        ac_prot_i  = 3'($urandom);
        @(negedge clk);
        ac_valid_i = 1'b0;
        ac_addr_i  = {$urandom, $urandom};
        check("lookup_req", lookup_req_o, 1'b1);
        check("lookup_addr", lookup_addr_o, aa);
        check("ac_ready_busy", ac_ready_o, 1'b0);
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            check("lookup_req_held", lookup_req_o, 1'b1);
        end
        lookup_gnt_i = 1'b1;
        if (same) begin
            give_result(hit, dirty, uniq, line, m, aa);
            @(negedge clk);
            lookup_gnt_i   = 1'b0;
            lookup_valid_i = 1'b0;
        end else begin
            @(negedge clk);
            lookup_gnt_i = 1'b0;
            check("lookup_req_drop", lookup_req_o, 1'b0);
            for (int i = 0; i < wait_dly; i++) begin
                check("upd_idle_wait", upd_valid_o, 1'b0);
                check("cr_idle_wait", cr_valid_o, 1'b0);
                @(negedge clk);
            end
            give_result(hit, dirty, uniq, line, m, aa);
            @(negedge clk);
            lookup_valid_i = 1'b0;
        end
        lookup_data_i = {8{$urandom}};

        check("cr_valid", cr_valid_o, 1'b1);
        check("cr_resp", cr_resp_o, er);
        check("upd_after", upd_valid_o, 1'b0);
        n = $urandom_range(0, stall_max);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("cr_valid_stall", cr_valid_o, 1'b1);
            check("cr_resp_stall", cr_resp_o, er);
        end
        cr_ready_i = 1'b1;
        @(negedge clk);
        cr_ready_i = 1'b0;
        check("cr_valid_done", cr_valid_o, 1'b0);

        if (er[0]) begin
            for (int b = 0; b < NB; b++) begin
                if (b == abort_beat) begin
                    rst_ni = 1'b0;
                    #1;
                    check("rst_cd_valid", cd_valid_o, 1'b0);
                    check("rst_cr_valid", cr_valid_o, 1'b0);
                    check("rst_lookup_req", lookup_req_o, 1'b0);
                    check("rst_upd_valid", upd_valid_o, 1'b0);
                    @(negedge clk);
                    rst_ni     = 1'b1;
                    cd_ready_i = 1'b0;
                    @(negedge clk);
                    check("rst_ac_ready", ac_ready_o, 1'b1);
                    check("rst_cd_after", cd_valid_o, 1'b0);
                    return;
                end
                n = $urandom_range(0, stall_max);
                for (int s = 0; s <= n; s++) begin
                    check("cd_valid", cd_valid_o, 1'b1);
                    check("cd_data", cd_data_o, line[b*DW +: DW]);
                    check("cd_last", cd_last_o, b == NB - 1);
                    if (s < n) @(negedge clk);
                end
                cd_ready_i = 1'b1;
                @(negedge clk);
                cd_ready_i = 1'b0;
            end
        end
        check("cd_valid_end", cd_valid_o, 1'b0);
        check("ac_ready_end", ac_ready_o, 1'b1);
    endtask

    initial begin
        logic [3:0]       c;
        logic [DW*NB-1:0] line;
        rst_ni          = 1'b0;
        ac_valid_i      = 1'b0;
        ac_addr_i       = '0;
        ac_snoop_i      = '0;
        ac_prot_i       = '0;
        cr_ready_i      = 1'b0;
        cd_ready_i      = 1'b0;
        lookup_gnt_i    = 1'b0;
        lookup_valid_i  = 1'b0;
        lookup_hit_i    = 1'b0;
        lookup_dirty_i  = 1'b0;
        lookup_unique_i = 1'b0;
        lookup_data_i   = '0;
        repeat (2) @(negedge clk);
        check("reset_ac_ready", ac_ready_o, 1'b1);
        check("reset_cr_valid", cr_valid_o, 1'b0);
        check("reset_cr_resp", cr_resp_o, 5'd0);
        check("reset_cd_valid", cd_valid_o, 1'b0);
        check("reset_cd_data", cd_data_o, 64'd0);
        check("reset_lookup_req", lookup_req_o, 1'b0);
        check("reset_lookup_addr", lookup_addr_o, 64'd0);
        check("reset_upd_valid", upd_valid_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk);

        line = {64'h4, 64'h3, 64'h2, 64'h1};
        check("plan_readshared_resp", {3'b000, model(4'd1, 1, 1, 1)},
              {3'b000, 3'b101, 5'b11101});
        run_snoop(4'd1, 64'h1234_5678_9abc_def7, 1, 1, 1, line, 0, 0, 0, 0, -1);
        run_snoop(4'd7, 64'h8000_0040, 0, 0, 0, line, 0, 0, 0, 0, -1);
        run_snoop(4'd9, 64'h0000_0123, 1, 0, 0, line, 0, 1, 0, 0, -1);
        run_snoop(4'd5, 64'hffff_ffe5, 1, 1, 1, line, 1, 0, 1, 0, -1);
        line = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
        run_snoop(4'd1, 64'h00ab_cd00, 1, 0, 1, line, 7, 0, 2, 3, -1);
        run_snoop(4'd0, 64'h0000_1000, 1, 1, 0, line, 0, 0, 0, 0, 2);
        line = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
        run_snoop(4'd7, 64'h0000_2020, 1, 1, 1, line, 2, 0, 1, 2, -1);

        for (int k = 0; k < 60; k++) begin
            c    = 4'($urandom);
            line = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            run_snoop(c, {$urandom, $urandom}, 1'($urandom),
                      1'($urandom), 1'($urandom), line,
                      $urandom_range(0, 3), 1'($urandom),
                      $urandom_range(0, 2), 3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Cache-side end of the ACE snoop channels. Accepts AC snoop requests issued by the coherency control unit and queries the local cache tag/data array.
- Returns a CR snoop response and, when required, one full cache line on CD. Issues the matching coherence state update (clean or invalidate) back to the cache.
- One instance sits between each cached master's L1 and the CCU snoop port. Only one snoop is outstanding at a time.

Parameters:
- AddrWidth, 64, width of ac_addr and cache addresses
- DataWidth, 64, CD data bus width in bits
- CdBeats, 4, CD beats per cache line; line size = DataWidth/8*CdBeats bytes (power of two)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- ac_valid_i  in  1  snoop request valid
- ac_ready_o  out  1  snoop request ready
- ac_addr_i  in  AddrWidth  snoop address
- ac_snoop_i  in  4  ACSNOOP encoding
- ac_prot_i  in  3  ACPROT; ignored
- cr_valid_o  out  1  snoop response valid
- cr_ready_i  in  1  snoop response ready
- cr_resp_o  out  5  CRRESP {WasUnique, IsShared, PassDirty, Error, DataTransfer}
- cd_valid_o  out  1  snoop data valid
- cd_ready_i  in  1  snoop data ready
- cd_data_o  out  DataWidth  snoop data beat
- cd_last_o  out  1  last beat of line
- lookup_req_o  out  1  cache lookup request
- lookup_gnt_i  in  1  lookup accepted
- lookup_addr_o  out  AddrWidth  line-aligned lookup address
- lookup_valid_i  in  1  lookup result valid, one-cycle pulse
- lookup_hit_i, lookup_dirty_i, lookup_unique_i  in  1 each  line state
- lookup_data_i  in  DataWidth*CdBeats  line data; beat 0 = LSBs
- upd_valid_o  out  1  one-cycle state-update pulse; cache must accept it
- upd_addr_o  out  AddrWidth  line-aligned update address
- upd_invalidate_o  out  1  set line Invalid
- upd_clean_o  out  1  clear dirty, set shared

Behaviour:
- Reset (async, rst_ni low): FSM goes to IDLE; all valid/req/upd outputs are 0; data, resp and address registers are 0. Reset mid-transaction abandons it silently.
- FSM states: IDLE -> LOOKUP -> WAIT -> RESP -> DATA -> IDLE.
- IDLE: ac_ready_o=1 (0 in every other state). On ac handshake, register the address with the line offset cleared, register ac_snoop, then go to LOOKUP.
- LOOKUP: lookup_req_o=1 and is held until lookup_gnt_i. On grant, go to WAIT. lookup_valid_i arriving in the grant cycle is accepted.
- WAIT: on lookup_valid_i, register the data line, compute the response, pulse upd_valid_o in the same cycle if an update is required, then go to RESP.
- RESP: cr_valid_o=1 and cr_resp_o stable until cr_ready_i. On handshake, go to DATA if DataTransfer=1, otherwise IDLE.
- DATA: beat counter runs 0..CdBeats-1. cd_last_o=1 on the final beat. Advance on each cd handshake; after the last beat handshake, go to IDLE. cd_valid_o is never deasserted before its handshake.
- Response table (snoop code: CRRESP and update):
  - Miss, any supported snoop: CRRESP=0, no update.
  - Hit ReadOnce 0000: DT=1, IS=1, PD=0, WU=unique; no update.
  - Hit ReadShared 0001 / ReadClean 0010 / ReadNotSharedDirty 0011: DT=1, IS=1, PD=dirty, WU=unique; upd_clean_o.
  - Hit ReadUnique 0111: DT=1, IS=0, PD=dirty, WU=unique; upd_invalidate_o.
  - Hit CleanShared 1000: DT=dirty, IS=1, PD=dirty, WU=unique; upd_clean_o.
  - Hit CleanInvalid 1001: DT=dirty, IS=0, PD=dirty, WU=unique; upd_invalidate_o.
  - Hit MakeInvalid 1101: DT=0, PD=0, IS=0, WU=unique; upd_invalidate_o.
  - Any other code: Error=1, all other bits 0, no lookup result used, no update. Still goes through LOOKUP so the flow is uniform.
- Timing: ac handshake at cycle T gives lookup_req_o at T+1. With lookup_valid_i at cycle V, cr_valid_o is at V+1 and the first cd_valid_o is the cycle after the CR handshake. Minimum one IDLE cycle between snoops.

Decomposition:
- ace_pkg holds the ACSNOOP code constants, the crresp_t packed struct and its bit positions, and the snoop_state_e FSM enum.
- Response/update derivation is a pure function in ace_pkg.
- One sub-module, ace_cd_serializer: a line register plus beat counter plus valid/last handshake, reused later by the CCU data path.

Test Plan:
- ReadShared, hit, dirty=1, unique=1, data=0x4..0x1 (4 beats) -> CRRESP=5'b11101, upd_clean_o pulse, CD beats 0x1,0x2,0x3,0x4 with cd_last_o only on the 4th.
- ReadUnique, miss -> CRRESP=0, no CD, no upd_valid_o; ac_ready_o back to 1 one cycle after the CR handshake.
- CleanInvalid, hit, clean, shared -> CRRESP=0, upd_invalidate_o=1, no CD.
- Unsupported code 0101 -> CRRESP=5'b00010, no update, no CD.
- Random cr_ready/cd_ready stalls and lookup_gnt held low for 7 cycles -> outputs stable while stalled, no dropped or duplicated beats.
- rst_ni asserted during beat 2 of DATA -> all valids 0 immediately, FSM in IDLE with ac_ready_o=1 after release; a new snoop then completes correctly.
